// File: rtl/bpu_update_sched_if.sv
// Write-port bus between the update scheduler and the predictor's BHT/BTB arrays.
// The master drives one write request, held stable until the predictor returns ready.
interface bpu_update_sched_if #(
   parameter int IDX_W = 8
);
   logic             upd_valid;
   logic             upd_ready;
   logic             upd_clear;
   logic [IDX_W-1:0] upd_index;
   logic [31:0]      upd_pc;
   logic             upd_taken;
   logic [31:0]      upd_target;

   modport master (
      output upd_valid,
      output upd_clear,
      output upd_index,
      output upd_pc,
      output upd_taken,
      output upd_target,
      input  upd_ready
   );

   modport slave (
      input  upd_valid,
      input  upd_clear,
      input  upd_index,
      input  upd_pc,
      input  upd_taken,
      input  upd_target,
      output upd_ready
   );
endinterface

// File: rtl/bpu_update_sched.sv
// Funnels two EX branch resolutions per cycle into the predictor's single write port,
// and sweeps every predictor index with clears after reset or on request.
module bpu_update_sched #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 8
) (
   input  logic                       cpu_clk,
   input  logic                       cpu_rstn,
   input  logic                       ex_valid1,
   input  logic                       ex_is_bj_1,
   input  logic                       real_taken1,
   input  logic [31:0]                ex_pc_1,
   input  logic [31:0]                real_addr1,
   input  logic                       ex_valid2,
   input  logic                       ex_is_bj_2,
   input  logic                       real_taken2,
   input  logic [31:0]                ex_pc_2,
   input  logic [31:0]                real_addr2,
   input  logic                       inv_req,
   bpu_update_sched_if.master         upd,
   output logic                       busy_init,
   output logic [$clog2(DEPTH):0]     q_count,
   output logic [15:0]                drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] ST_RST  = 2'd0;
   localparam logic [1:0] ST_INIT = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   logic [1:0]       state;
   logic [IDX_W-1:0] sweep_cnt;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             inv_pend;

   logic [31:0]      q_pc     [DEPTH];
   logic             q_taken  [DEPTH];
   logic [31:0]      q_target [DEPTH];

   logic             is_run;
   logic             is_init;
   logic             e1;
   logic             e2;
   logic [CNT_W-1:0] free;
   logic             push1;
   logic             push2;
   logic [CNT_W-1:0] n_push;
   logic [1:0]       n_drop;
   logic             head_vld;
   logic             valid_o;
   logic             pop;
   logic             go_init;
   logic [PTR_W-1:0] wr_ptr2;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {15'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   always_comb begin
      is_run   = (state == ST_RUN);
      is_init  = (state == ST_INIT);
      e1       = ex_valid1 & ex_is_bj_1;
      // a taken older branch makes the younger slot wrong-path, so it is neither queued nor a drop
      e2       = ex_valid2 & ex_is_bj_2 & ~(ex_valid1 & real_taken1);
      free     = CNT_W'(DEPTH) - q_count;
      push1    = is_run & e1 & (free != '0);
      push2    = is_run & e2 & (e1 ? (free > CNT_W'(1)) : (free != '0));
      n_push   = CNT_W'(push1) + CNT_W'(push2);
      n_drop   = {1'b0, e1 & ~push1} + {1'b0, e2 & ~push2};
      head_vld = is_run & (q_count != '0);
      valid_o  = is_init | head_vld;
      pop      = head_vld & upd.upd_ready;
      go_init  = is_run & inv_pend & (~valid_o | upd.upd_ready);
      wr_ptr2  = wr_ptr + PTR_W'(push1);
   end

   assign upd.upd_valid  = valid_o;
   assign upd.upd_clear  = is_init;
   assign upd.upd_index  = is_init  ? sweep_cnt :
                           head_vld ? q_pc[rd_ptr][IDX_W+1:2] : '0;
   assign upd.upd_pc     = head_vld ? q_pc[rd_ptr]     : 32'h0;
   assign upd.upd_taken  = head_vld ? q_taken[rd_ptr]  : 1'b0;
   assign upd.upd_target = head_vld ? q_target[rd_ptr] : 32'h0;
   assign busy_init      = ~is_run;

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state      <= ST_RST;
         sweep_cnt  <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         q_count    <= '0;
         drop_count <= 16'h0;
         inv_pend   <= 1'b0;
      end else begin
         drop_count <= sat_add16(drop_count, n_drop);
         case (state)
            ST_RST: state <= ST_INIT;
            ST_INIT: begin
               if (upd.upd_ready) begin
                  sweep_cnt <= sweep_cnt + 1'b1;
                  if (&sweep_cnt) state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // queued entries are stale once the arrays are cleared, so they are simply discarded
               if (go_init) begin
                  state    <= ST_INIT;
                  rd_ptr   <= '0;
                  wr_ptr   <= '0;
                  q_count  <= '0;
                  inv_pend <= 1'b0;
               end else begin
                  rd_ptr  <= rd_ptr + PTR_W'(pop);
                  wr_ptr  <= wr_ptr + PTR_W'(n_push);
                  q_count <= q_count + n_push - CNT_W'(pop);
                  if (inv_req) inv_pend <= 1'b1;
               end
            end
            default: state <= ST_RST;
         endcase
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (push1) begin
         q_pc[wr_ptr]     <= ex_pc_1;
         q_taken[wr_ptr]  <= real_taken1;
         q_target[wr_ptr] <= real_addr1;
      end
      if (push2) begin
         q_pc[wr_ptr2]     <= ex_pc_2;
         q_taken[wr_ptr2]  <= real_taken2;
         q_target[wr_ptr2] <= real_addr2;
      end
   end

endmodule

// File: doc/bpu_update_sched.md
# bpu_update_sched

Update scheduler between the dual-issue EX stage and the branch predictor's single BHT/BTB write port. Each cycle it filters both EX branch resolutions and enqueues them in program order into a small FIFO. It then drains one update per cycle to the predictor through a valid/ready handshake. After reset, and on request, it also runs an invalidation sweep over every predictor index, so the predictor arrays need no reset of their own.

## Interface
- `DEPTH`, default 4, queue entries; power of 2, at least 2.
- `IDX_W`, default 8, predictor index width; the index is `pc[IDX_W+1:2]`.

- `cpu_clk`  in  1  clock.
- `cpu_rstn`  in  1  asynchronous active-low reset.
- `ex_valid1`, `ex_is_bj_1`, `real_taken1`  in  1 each  slot-1 resolution (older instruction).
- `ex_pc_1`, `real_addr1`  in  32 each  slot-1 PC and resolved next PC.
- `ex_valid2`, `ex_is_bj_2`, `real_taken2`  in  1 each  slot-2 resolution (younger instruction).
- `ex_pc_2`, `real_addr2`  in  32 each  slot-2 PC and resolved next PC.
- `inv_req`  in  1  one-cycle pulse requesting a full predictor invalidation.
- `upd_valid`  out  1  write request to the predictor.
- `upd_ready`  in  1  predictor accepts the write this cycle.
- `upd_clear`  out  1  1 means invalidate the entry at `upd_index`; 0 means a normal update.
- `upd_index`  out  IDX_W  target index.
- `upd_pc`  out  32  branch PC; the tag is taken from it.
- `upd_taken`  out  1  resolved direction.
- `upd_target`  out  32  resolved target.
- `busy_init`  out  1  high in states RST and INIT.
- `q_count`  out  $clog2(DEPTH)+1  queue occupancy.
- `drop_count`  out  16  number of eligible updates lost; saturates.

## Operation
**States: RST, INIT, RUN.**
- Asynchronous reset forces:
  - state RST, sweep counter 0, queue empty;
  - `drop_count` 0 and the `inv_req` latch cleared.
- RST lasts exactly one cycle after `cpu_rstn` rises, then moves to INIT.
- INIT drives `upd_valid`=1, `upd_clear`=1, `upd_index`=sweep counter. `upd_pc`, `upd_taken` and `upd_target` are 0.
  - The sweep counter advances on each accepted handshake.
  - After index 2^IDX_W-1 is accepted, the state moves to RUN and the counter returns to 0.
- RUN:
  - `upd_valid` = (`q_count`!=0) and `upd_clear`=0.
  - Payload is the head entry; `upd_index` = head `pc[IDX_W+1:2]`.
  - The head is popped when `upd_valid & upd_ready`.

**Eligibility:**
- e1 = `ex_valid1 & ex_is_bj_1`.
- e2 = `ex_valid2 & ex_is_bj_2 & !(ex_valid1 & real_taken1)`.
- A slot-2 update suppressed by a taken slot 1 is a wrong-path instruction. It is not counted as a drop.

**Enqueue (RUN only):**
- free = DEPTH − `q_count`, using the registered value before the same-cycle pop.
- Slot 1 is written first, slot 2 into the next location; program order is preserved.
- If free=1 and both slots are eligible, slot 1 is accepted and slot 2 is dropped.
- If free=0, all eligible updates are dropped.
- Same-cycle pop and push are allowed.
- `q_count` next = `q_count` + pushes − pop.

**Drops:**
- Every eligible update that is not enqueued increments `drop_count`, by 0, 1 or 2 per cycle.
- This includes eligible updates arriving in RST or INIT.
- `drop_count` holds at 16'hFFFF.

**Invalidation request:**
- An `inv_req` pulse in RUN sets a pending latch.
- The transition RUN→INIT happens at the first edge where no transfer is outstanding, i.e. `!upd_valid | upd_ready`. Any handshake in that cycle completes first.
- On entering INIT, the queue is emptied (stale). Discarded entries are not counted as drops.
- `inv_req` in RST or INIT is ignored.

**Pointers:** read and write pointers wrap modulo DEPTH.

## Timing
- **Handshake:** once `upd_valid` is high, `upd_valid`, `upd_clear`, `upd_index`, `upd_pc`, `upd_taken` and `upd_target` stay stable until the cycle `upd_ready`=1.
- **Latency:** an update enqueued at edge N appears on `upd_valid` in cycle N+1 if the queue was empty. There is no combinational path from ex_* inputs to upd_* outputs.
- **Throughput:**
  - 1 update per cycle with `upd_ready` tied high.
  - A full sweep takes 2^IDX_W cycles with `upd_ready`=1.
  - The first RUN cycle is reset release + 1 + 2^IDX_W.
- **Reset values:** `upd_valid`=0, `upd_clear`=0, `upd_index`=0, `upd_pc`=0, `upd_taken`=0, `upd_target`=0, `busy_init`=1, `q_count`=0, `drop_count`=0.
- **Reset mid-sweep or mid-handshake:** all state is abandoned immediately; the block restarts from RST.

## Test plan
- **Reset and sweep:**
  - Stimulus: release reset, `upd_ready`=1, IDX_W=8.
  - Required: `upd_valid`=0 for 1 cycle, then 256 clears with indices 0..255 in order; `busy_init` falls in the cycle after index 255 is accepted.
- **Ordering:**
  - Stimulus: in RUN, both slots are branches with slot 1 not taken; `ex_pc_1`=0x1C000010, `ex_pc_2`=0x1C000014.
  - Required: two updates in order, `upd_index` 0x04 then 0x05; `drop_count` stays 0.
- **Wrong-path suppression:**
  - Stimulus: `real_taken1`=1, slot 2 is a branch.
  - Required: exactly one update (slot 1), `q_count` peaks at 1, `drop_count` stays 0.
- **Overflow:**
  - Stimulus: `upd_ready`=0, DEPTH=4; drive 3 single-slot branches, then one dual-branch cycle with slot 1 not taken.
  - Required: `q_count`=4; `drop_count`=1; after releasing `upd_ready`, 4 updates appear in order.
- **Backpressure stability:**
  - Stimulus: hold `upd_ready`=0 for 5 cycles while new branches keep arriving.
  - Required: all upd_* outputs remain constant; the head entry is unchanged.
- **Invalidate during stall:**
  - Stimulus: `inv_req` pulse while `upd_valid`=1 and `upd_ready`=0 with 2 entries queued; then `upd_ready`=1.
  - Required: the head transfer completes first, the next cycle shows `upd_clear`=1 with `upd_index`=0, the remaining entry is discarded, and `drop_count` is unchanged.
